instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the RV32I core.
- Issues instruction-memory reads, holds the fetched word in an instruction register, and presents it to the combinational instruction decoder.
- On a legal decode, starts the execute unit and waits for completion, then advances the PC.
- On an illegal decode, raises a trap pulse and halts until reset.

---
 rtl/instr_sequencer_pkg.sv | 16 +
 rtl/instr_sequencer.sv | 90 +++++++++
 tb/tb_instr_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types for the RV32I fetch/decode/execute sequencer.
package instr_sequencer_pkg;

    typedef logic [31:0] t_word;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        EXECUTE,
        HALT
    } t_seq_state;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller: fetches a word, holds it for the decoder,
// starts execution on a legal decode and halts with a trap pulse on an illegal one.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter t_word       RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = INSTR_BYTES
) (
    input  logic  clk,
    input  logic  rst,

    output logic  imem_req_valid,
    output t_word imem_req_addr,
    input  logic  imem_req_ready,
    input  logic  imem_rsp_valid,
    input  t_word imem_rsp_data,

    output t_word dec_instr,
    input  logic  dec_valid,

    output logic  exec_start,
    input  logic  exec_done,

    output t_word pc,
    output t_word retired,
    output logic  illegal_instr,
    output logic  halted
);

    t_seq_state state;
    t_word      ir;

    // Outputs depend on registers only, never directly on inputs.
    assign imem_req_valid = (state == FETCH_REQ);
    assign imem_req_addr  = pc;
    assign dec_instr      = ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH_REQ;
            pc            <= RESET_PC;
            ir            <= '0;
            retired       <= '0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
            exec_start    <= 1'b0;
        end else begin
            exec_start    <= 1'b0;
            illegal_instr <= 1'b0;
            unique case (state)
                FETCH_REQ: begin
                    if (imem_req_ready) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir    <= imem_rsp_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_valid) begin
                        exec_start <= 1'b1;
                        state      <= EXECUTE;
                    end else begin
                        // pc is left on the faulting instruction for the trap handler.
                        illegal_instr <= 1'b1;
                        halted        <= 1'b1;
                        state         <= HALT;
                    end
                end
                EXECUTE: begin
                    if (exec_done) begin
                        pc      <= pc + t_word'(PC_STEP);
                        retired <= retired + 32'd1;
                        state   <= FETCH_REQ;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: a per-cycle plan of stimulus and expected outputs is built from
// per-instruction timing (ready delay, response wait, execute wait) and replayed.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam t_word RESET_PC = 32'h0000_0000;
    localparam t_word WRAP_PC  = 32'hFFFF_FFFC;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  ready = 1'b0, rsp_valid = 1'b0, dec_valid = 1'b0, exec_done = 1'b0;
    t_word rsp_data = '0;

    logic  req_valid, exec_start, illegal_instr, halted;
    t_word req_addr, dec_instr, pc, retired;
    logic  w_req_valid, w_exec_start, w_illegal_instr, w_halted;
    t_word w_req_addr, w_dec_instr, w_pc, w_retired;

    always #5 clk = ~clk;

    instr_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .dec_instr(dec_instr), .dec_valid(dec_valid),
        .exec_start(exec_start), .exec_done(exec_done),
        .pc(pc), .retired(retired), .illegal_instr(illegal_instr), .halted(halted)
    );

    // Same stimulus, reset PC at the top of the address space to exercise wrap-around.
    instr_sequencer #(.RESET_PC(WRAP_PC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .dec_instr(w_dec_instr), .dec_valid(dec_valid),
        .exec_start(w_exec_start), .exec_done(exec_done),
        .pc(w_pc), .retired(w_retired), .illegal_instr(w_illegal_instr), .halted(w_halted)
    );

    typedef struct {
        logic  ready, rsp_valid, dec_valid, done;
        t_word rsp_data;
        logic  exp_req_valid, exp_start, exp_illegal, exp_halted;
        t_word exp_pc, exp_ir, exp_retired;
    } cyc_t;

    cyc_t  plan[$];
    t_word m_pc, m_ir, m_retired;
    logic  m_halted;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    task automatic check(input string tag, input t_word got, input t_word exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic nz();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_cycle(input logic rdy, input logic rv, input t_word rdata,
                             input logic dv, input logic dn,
                             input logic rqv, input logic st, input logic ill);
        cyc_t c;
        c.ready = rdy; c.rsp_valid = rv; c.rsp_data = rdata; c.dec_valid = dv; c.done = dn;
        c.exp_req_valid = rqv; c.exp_start = st; c.exp_illegal = ill;
        c.exp_halted = m_halted; c.exp_pc = m_pc; c.exp_ir = m_ir; c.exp_retired = m_retired;
        plan.push_back(c);
    endtask

    // Fetch request (rd stall cycles), response wait (rw empty cycles), then decode.
    task automatic gen_front(input int rd, input int rw, input logic legal, input t_word word);
        for (int i = 0; i < rd; i++) add_cycle(1'b0, nz(), $urandom, nz(), nz(), 1'b1, 1'b0, 1'b0);
        add_cycle(1'b1, nz(), $urandom, nz(), nz(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < rw; i++) add_cycle(nz(), 1'b0, $urandom, nz(), nz(), 1'b0, 1'b0, 1'b0);
        add_cycle(nz(), 1'b1, word, nz(), nz(), 1'b0, 1'b0, 1'b0);
        m_ir = word;
        add_cycle(nz(), nz(), $urandom, legal, nz(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gen_instr(input int rd, input int rw, input int dd, input t_word word);
        gen_front(rd, rw, 1'b1, word);
        for (int i = 0; i <= dd; i++)
            add_cycle(nz(), nz(), $urandom, nz(), i == dd, 1'b0, i == 0, 1'b0);
        m_pc = m_pc + 32'd4;
        m_retired = m_retired + 32'd1;
    endtask

    task automatic gen_illegal(input int rd, input int rw, input int idle);
        gen_front(rd, rw, 1'b0, 32'h0000_0000);
        m_halted = 1'b1;
        add_cycle(nz(), nz(), $urandom, nz(), nz(), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < idle; i++) add_cycle(1'b1, nz(), $urandom, nz(), nz(), 1'b0, 1'b0, 1'b0);
    endtask

    // Legal instruction whose execute never completes before the plan ends.
    task automatic gen_cut(input int exec_cycles);
        gen_front(0, 1, 1'b1, 32'h0000_0013);
        for (int i = 0; i < exec_cycles; i++)
            add_cycle(nz(), nz(), $urandom, nz(), 1'b0, 1'b0, i == 0, 1'b0);
    endtask

    task automatic run_plan();
        foreach (plan[i]) begin
            check("req_valid", 32'(req_valid), 32'(plan[i].exp_req_valid));
            check("req_addr", req_addr, plan[i].exp_pc);
            check("pc", pc, plan[i].exp_pc);
            check("dec_instr", dec_instr, plan[i].exp_ir);
            check("exec_start", 32'(exec_start), 32'(plan[i].exp_start));
            check("retired", retired, plan[i].exp_retired);
            check("illegal", 32'(illegal_instr), 32'(plan[i].exp_illegal));
            check("halted", 32'(halted), 32'(plan[i].exp_halted));
            check("wrap_pc", w_pc, plan[i].exp_pc + WRAP_PC - RESET_PC);
            check("wrap_addr", w_req_addr, plan[i].exp_pc + WRAP_PC - RESET_PC);
            ready = plan[i].ready;
            rsp_valid = plan[i].rsp_valid;
            rsp_data = plan[i].rsp_data;
            dec_valid = plan[i].dec_valid;
            exec_done = plan[i].done;
            @(negedge clk);
            cyc++;
        end
        plan.delete();
    endtask

    // Reset with every other input active to show rst overrides them.
    task automatic do_reset(input int n);
        rst = 1'b1;
        ready = 1'b1; rsp_valid = 1'b1; dec_valid = 1'b1; exec_done = 1'b1; rsp_data = $urandom;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_pc = RESET_PC; m_ir = '0; m_retired = '0; m_halted = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        gen_instr(0, 0, 0, 32'h0050_0093);
        gen_instr(3, 0, 0, $urandom | 32'h1);
        gen_illegal(0, 0, 20);
        run_plan();

        do_reset(1);
        gen_instr(0, 4, 3, 32'h1234_5137);
        for (int k = 0; k < 25; k++)
            gen_instr($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom | 32'h1);
        gen_cut(3);
        run_plan();

        do_reset(2);
        for (int k = 0; k < 10; k++)
            gen_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom | 32'h1);
        gen_illegal($urandom_range(0, 3), $urandom_range(0, 3), 20);
        run_plan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
